// File: rtl/mem_log_reader.sv
// Drains the sample log memory once it is full, sending each 16-bit word as
// two bytes (I then Q) over a valid/ready byte stream.
module mem_log_reader #(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = 16,
  parameter int RD_LATENCY      = 1
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic                       i_start_dump,
  input  logic                       i_abort,
  input  logic                       i_mem_full,
  output logic                       o_read_log,
  output logic [BRAM_ADDR_WIDTH-1:0] o_addr_log_to_mem,
  input  logic [BRAM_DATA_WIDTH-1:0] i_data_log_from_mem,
  output logic [7:0]                 o_byte,
  output logic                       o_byte_valid,
  input  logic                       i_byte_ready,
  output logic                       o_busy,
  output logic                       o_done
);

  // state   | meaning
  // IDLE    | waiting for a dump request while the log is full
  // ARM     | one cycle of read request at address 0 so the log enters read mode
  // FETCH   | address held, latency counter runs down, word captured at terminal count
  // SEND_HI | I byte (word[15:8]) offered until accepted
  // SEND_LO | Q byte (word[7:0]) offered; on accept step address or finish
  // DONE    | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_FETCH, S_SEND_HI, S_SEND_LO, S_DONE
  } state_t;

  localparam logic [2:0] LAT_LOAD = 3'(RD_LATENCY - 1);
  localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ONE = {{(BRAM_ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                     state, state_nxt;
  logic [BRAM_ADDR_WIDTH-1:0] addr;
  logic [BRAM_DATA_WIDTH-1:0] word;
  logic [2:0]                 lat_cnt;
  logic                       xfer;
  logic                       lat_tc;
  logic                       addr_last;

  assign xfer      = o_byte_valid & i_byte_ready;
  assign lat_tc    = (lat_cnt == 3'd0);
  assign addr_last = &addr;

  always_ff @(posedge clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (i_start_dump && i_mem_full) state_nxt = S_ARM;
      S_ARM:     state_nxt = S_FETCH;
      S_FETCH:   if (lat_tc) state_nxt = S_SEND_HI;
      S_SEND_HI: if (xfer) state_nxt = S_SEND_LO;
      S_SEND_LO: if (xfer) state_nxt = addr_last ? S_DONE : S_FETCH;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    // abort wins over any transition, including a same-cycle byte accept
    if (i_abort && (state != S_IDLE)) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      addr    <= '0;
      word    <= '0;
      lat_cnt <= 3'd0;
    end else begin
      if ((state_nxt == S_IDLE) || (state_nxt == S_ARM))
        addr <= '0;
      else if ((state == S_SEND_LO) && (state_nxt == S_FETCH))
        addr <= addr + ADDR_ONE;

      if ((state_nxt == S_FETCH) && (state != S_FETCH))
        lat_cnt <= LAT_LOAD;
      else if ((state == S_FETCH) && !lat_tc)
        lat_cnt <= lat_cnt - 3'd1;

      if ((state == S_FETCH) && lat_tc)
        word <= i_data_log_from_mem;
    end
  end

  always_comb begin
    o_busy       = (state != S_IDLE);
    o_read_log   = (state != S_IDLE);
    o_byte       = 8'h00;
    o_byte_valid = 1'b0;
    o_done       = 1'b0;
    case (state)
      S_SEND_HI: begin
        o_byte       = word[15:8];
        o_byte_valid = 1'b1;
      end
      S_SEND_LO: begin
        o_byte       = word[7:0];
        o_byte_valid = 1'b1;
      end
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_addr_log_to_mem = addr;

endmodule

// File: tb/tb_mem_log_reader.sv
// Directed bench: two dump controllers (read latency 1 and 3, 8-word log)
// driven in lockstep, byte streams compared against a hand-written table.
module tb_mem_log_reader;

  typedef logic [7:0] bq_t [$];
  typedef struct {
    logic [2:0] addr;
    logic [7:0] hi;
    logic [7:0] lo;
  } vec_t;

  logic clk = 1'b0;
  logic rst, start, abort, full, ready;

  logic       read1, v1, busy1, done1;
  logic [2:0] addr1;
  logic [15:0] data1;
  logic [7:0] byte1;

  logic       read3, v3, busy3, done3;
  logic [2:0] addr3;
  logic [15:0] data3, m1, m2;
  logic [7:0] byte3;

  int checks = 0;
  int errors = 0;
  int nd1 = 0, nd3 = 0;
  bq_t q1, q3;
  vec_t tbl [8];
  logic stall1 = 1'b0, stall3 = 1'b0;
  logic [7:0] held1, held3;

  always #5 clk = ~clk;

  mem_log_reader #(.BRAM_ADDR_WIDTH(3), .BRAM_DATA_WIDTH(16), .RD_LATENCY(1)) u_l1 (
    .clk(clk), .i_rst(rst), .i_start_dump(start), .i_abort(abort), .i_mem_full(full),
    .o_read_log(read1), .o_addr_log_to_mem(addr1), .i_data_log_from_mem(data1),
    .o_byte(byte1), .o_byte_valid(v1), .i_byte_ready(ready), .o_busy(busy1), .o_done(done1));

  mem_log_reader #(.BRAM_ADDR_WIDTH(3), .BRAM_DATA_WIDTH(16), .RD_LATENCY(3)) u_l3 (
    .clk(clk), .i_rst(rst), .i_start_dump(start), .i_abort(abort), .i_mem_full(full),
    .o_read_log(read3), .o_addr_log_to_mem(addr3), .i_data_log_from_mem(data3),
    .o_byte(byte3), .o_byte_valid(v3), .i_byte_ready(ready), .o_busy(busy3), .o_done(done3));

  function automatic logic [15:0] mem_word(input logic [2:0] a);
    logic [7:0] w;
    w = {5'b0, a};
    return {w + 8'h10, ~w};
  endfunction

  // latency 1: combinational read; latency 3: two register stages
  assign data1 = mem_word(addr1);
  always @(posedge clk) begin
    m1 <= mem_word(addr3);
    m2 <= m1;
  end
  assign data3 = m2;

  always @(posedge clk) begin
    if (!rst && v1 && ready) q1.push_back(byte1);
    if (!rst && v3 && ready) q3.push_back(byte3);
    if (!rst && done1) nd1++;
    if (!rst && done3) nd3++;
    if (stall1) begin
      checks++;
      if (!(v1 && byte1 == held1)) begin
        errors++;
        $display("FAIL stall_hold_l1 act valid=%0b byte=%02h exp valid=1 byte=%02h", v1, byte1, held1);
      end
    end
    if (stall3) begin
      checks++;
      if (!(v3 && byte3 == held3)) begin
        errors++;
        $display("FAIL stall_hold_l3 act valid=%0b byte=%02h exp valid=1 byte=%02h", v3, byte3, held3);
      end
    end
    stall1 = v1 && !ready && !abort && !rst;
    stall3 = v3 && !ready && !abort && !rst;
    held1  = byte1;
    held3  = byte3;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic chk_bytes(input string tag, input bq_t q, input int n_words);
    chk({tag, "_count"}, q.size(), 2 * n_words);
    for (int i = 0; i < n_words; i++) begin
      if (q.size() >= 2 * i + 2) begin
        chk($sformatf("%s_hi%0d", tag, tbl[i].addr), q[2*i],   tbl[i].hi);
        chk($sformatf("%s_lo%0d", tag, tbl[i].addr), q[2*i+1], tbl[i].lo);
      end
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_read1"},  read1, 0);  chk({tag, "_read3"},  read3, 0);
    chk({tag, "_addr1"},  addr1, 0);  chk({tag, "_addr3"},  addr3, 0);
    chk({tag, "_byte1"},  byte1, 0);  chk({tag, "_byte3"},  byte3, 0);
    chk({tag, "_valid1"}, v1, 0);     chk({tag, "_valid3"}, v3, 0);
    chk({tag, "_busy1"},  busy1, 0);  chk({tag, "_busy3"},  busy3, 0);
    chk({tag, "_done1"},  done1, 0);  chk({tag, "_done3"},  done3, 0);
  endtask

  // Labels count cycles after the start edge: label k is sampled just before edge k.
  task automatic run_dump(input bit bp, output int d1, output int d3,
                          output int f1, output int f3);
    bit finished;
    d1 = 0; d3 = 0; f1 = 0; f3 = 0; finished = 0;
    q1.delete(); q3.delete();
    @(negedge clk); start = 1'b1; ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      if (bp) ready = (k % 4 == 0) || (k % 4 == 3);
      if (v1 && f1 == 0) f1 = k;
      if (v3 && f3 == 0) f3 = k;
      if (done1) d1 = k;
      if (done3) d3 = k;
      if (k > 2 && !busy1 && !busy3) begin
        finished = 1;
        break;
      end
      @(negedge clk);
    end
    ready = 1'b1;
    chk("dump_finished_in_budget", finished, 1);
  endtask

  initial begin
    int d1, d3, f1, f3, n1, n3;
    bit seen_busy, seen_read, found;

    tbl[0] = '{3'd0, 8'h10, 8'hFF};
    tbl[1] = '{3'd1, 8'h11, 8'hFE};
    tbl[2] = '{3'd2, 8'h12, 8'hFD};
    tbl[3] = '{3'd3, 8'h13, 8'hFC};
    tbl[4] = '{3'd4, 8'h14, 8'hFB};
    tbl[5] = '{3'd5, 8'h15, 8'hFA};
    tbl[6] = '{3'd6, 8'h16, 8'hF9};
    tbl[7] = '{3'd7, 8'h17, 8'hF8};

    rst = 1'b1; start = 1'b0; abort = 1'b0; full = 1'b1; ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b0;
    @(negedge clk);

    // basic dump, ready tied high
    n1 = nd1; n3 = nd3;
    run_dump(0, d1, d3, f1, f3);
    chk_bytes("basic_l1", q1, 8);
    chk_bytes("basic_l3", q3, 8);
    chk("basic_done_cycle_l1", d1, 26);
    chk("basic_done_cycle_l3", d3, 42);
    chk("first_valid_l1", f1, 3);
    chk("first_valid_l3", f3, 5);
    chk("done_pulses_l1", nd1 - n1, 1);
    chk("done_pulses_l3", nd3 - n3, 1);

    // start while the log is not full is ignored
    full = 1'b0; q1.delete(); q3.delete();
    seen_busy = 0; seen_read = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (busy1 || busy3) seen_busy = 1;
      if (read1 || read3) seen_read = 1;
      @(negedge clk);
    end
    chk("nofull_busy", seen_busy, 0);
    chk("nofull_read", seen_read, 0);
    chk("nofull_bytes", q1.size() + q3.size(), 0);
    full = 1'b1;
    run_dump(0, d1, d3, f1, f3);
    chk_bytes("after_full_l1", q1, 8);
    chk("after_full_done_l1", d1, 26);

    // backpressure: ready pattern 1-0-0-1
    n1 = nd1;
    run_dump(1, d1, d3, f1, f3);
    chk_bytes("bp_l1", q1, 8);
    chk_bytes("bp_l3", q3, 8);
    chk("bp_done_seen_l1", nd1 - n1, 1);

    // abort in SEND_LO of word 2 (Q byte FD on offer)
    n1 = nd1; n3 = nd3; found = 0;
    q1.delete(); q3.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (v1 && addr1 == 3'd2 && byte1 == 8'hFD) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("abort_reached_send_lo", found, 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_busy1", busy1, 0);
    chk("abort_valid1", v1, 0);
    chk("abort_read1", read1, 0);
    chk("abort_addr1", addr1, 0);
    chk("abort_busy3", busy3, 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done_l1", nd1 - n1, 0);
    chk("abort_no_done_l3", nd3 - n3, 0);
    chk_bytes("abort_partial_l1", q1, 3);
    run_dump(0, d1, d3, f1, f3);
    chk_bytes("after_abort_l1", q1, 8);
    chk_bytes("after_abort_l3", q3, 8);

    // synchronous reset during FETCH, start held high in the reset cycle
    n1 = nd1; n3 = nd3;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy1", busy1, 1);
    chk("pre_rst_valid1", v1, 0);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    chk_reset_outs("midrst");
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("post_rst_busy1", busy1, 0);
    chk("post_rst_busy3", busy3, 0);
    chk("rst_no_done", (nd1 - n1) + (nd3 - n3), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
